// File: rtl/router_pkg.sv
// Shared constants for the router ingress path: nibble width, output count and
// the sel encodings driven towards router_1x3_4bit.
package router_pkg;
   localparam int DATA_W  = 4;
   localparam int NUM_OUT = 3;
   localparam int SEL_W   = 2;

   localparam logic [SEL_W-1:0] OUT0        = 2'd0;
   localparam logic [SEL_W-1:0] OUT1        = 2'd1;
   localparam logic [SEL_W-1:0] OUT2        = 2'd2;
   localparam logic [SEL_W-1:0] SEL_INVALID = 2'b11;
endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin grant: searches from the pointer and moves the pointer
// one past the winner whenever the winning request is actually taken.
module rr_arbiter3
   import router_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] eligible,
   input  logic       advance,
   output logic [2:0] grant,
   output logic [1:0] grant_idx
);

   logic [1:0] ptr;
   logic [2:0] sum;
   logic [1:0] cand;
   logic       found;

   always_comb begin
      grant     = '0;
      grant_idx = ptr;
      found     = 1'b0;
      sum       = '0;
      cand      = '0;
      for (int k = 0; k < NUM_OUT; k++) begin
         sum = {1'b0, ptr} + 3'(k);
         if (sum >= 3'd3) sum = sum - 3'd3;
         cand = sum[1:0];
         if (!found && eligible[cand]) begin
            grant[cand] = 1'b1;
            grant_idx   = cand;
            found       = 1'b1;
         end
      end
      if (rst) grant = '0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ptr <= '0;
      else if (advance)
         ptr <= (grant_idx == 2'd2) ? 2'd0 : grant_idx + 2'd1;
   end

endmodule

// File: rtl/router_ingress_arbiter.sv
// Credit-aware round-robin front end for the single ingress port of
// router_1x3_4bit; illegal destinations are swallowed and counted.
module router_ingress_arbiter
   import router_pkg::*;
#(
   parameter int DATA_W  = router_pkg::DATA_W,
   parameter int CREDITS = 4,
   parameter int CNT_W   = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [2:0]            req_valid,
   input  logic [3*DATA_W-1:0]   req_data,
   input  logic [5:0]            req_dest,
   output logic [2:0]            req_ready,
   input  logic [2:0]            credit_return,
   output logic [DATA_W-1:0]     router_data_in,
   output logic [1:0]            router_sel,
   output logic                  router_valid_in,
   output logic [2:0]            credit_empty,
   output logic [CNT_W-1:0]      drop_count,
   output logic                  credit_err
);

   localparam int                CRED_W   = 3;
   localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(CREDITS);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

   logic [CRED_W-1:0] credit [NUM_OUT];
   logic [SEL_W-1:0]  dest   [NUM_OUT];
   logic [DATA_W-1:0] data   [NUM_OUT];
   logic [3:0]        has_credit;
   logic [2:0]        eligible;
   logic [2:0]        grant;
   logic [1:0]        grant_idx;
   logic              accept;
   logic              legal;
   logic [SEL_W-1:0]  g_dest;
   logic [DATA_W-1:0] g_data;
   logic [2:0]        dec;

   logic [DATA_W-1:0] data_p1;
   logic [SEL_W-1:0]  sel_p1;
   logic              vld_p1;
   logic [CNT_W-1:0]  drop_p1;
   logic              err_p1;

   // Request decode and eligibility (illegal destination never needs a credit)
   always_comb begin
      for (int i = 0; i < NUM_OUT; i++) begin
         dest[i]         = req_dest[2*i +: 2];
         data[i]         = req_data[DATA_W*i +: DATA_W];
         credit_empty[i] = (credit[i] == '0);
         has_credit[i]   = ~credit_empty[i];
      end
      has_credit[3] = 1'b1;
      for (int i = 0; i < NUM_OUT; i++)
         eligible[i] = req_valid[i] & has_credit[dest[i]];
   end

   rr_arbiter3 u_rr (
      .clk       (clk),
      .rst       (rst),
      .eligible  (eligible),
      .advance   (accept),
      .grant     (grant),
      .grant_idx (grant_idx)
   );

   always_comb begin
      case (grant_idx)
         2'd1:    begin g_dest = dest[1]; g_data = data[1]; end
         2'd2:    begin g_dest = dest[2]; g_data = data[2]; end
         default: begin g_dest = dest[0]; g_data = data[0]; end
      endcase
      accept = |grant;
      legal  = accept && (g_dest != SEL_INVALID);
      dec    = '0;
      for (int j = 0; j < NUM_OUT; j++)
         dec[j] = legal && (g_dest == SEL_W'(j));
   end

   assign req_ready = grant;

   // Stage p1: registered router drive, credits and drop statistics
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_p1 <= '0;
         sel_p1  <= '0;
         vld_p1  <= 1'b0;
         drop_p1 <= '0;
         err_p1  <= 1'b0;
         for (int j = 0; j < NUM_OUT; j++)
            credit[j] <= CRED_MAX;
      end else begin
         vld_p1 <= legal;
         if (legal) begin
            data_p1 <= g_data;
            sel_p1  <= g_dest;
         end
         if (accept && !legal)
            drop_p1 <= sat_inc(drop_p1);
         for (int j = 0; j < NUM_OUT; j++) begin
            if (dec[j] && !credit_return[j])
               credit[j] <= credit[j] - 1'b1;
            else if (credit_return[j] && !dec[j]) begin
               if (credit[j] == CRED_MAX)
                  err_p1 <= 1'b1;
               else
                  credit[j] <= credit[j] + 1'b1;
            end
         end
      end
   end

   assign router_data_in  = data_p1;
   assign router_sel      = sel_p1;
   assign router_valid_in = vld_p1;
   assign drop_count      = drop_p1;
   assign credit_err      = err_p1;

endmodule

// File: tb/tb_router_ingress_arbiter.sv
// Randomised and directed bench for router_ingress_arbiter against a
// transaction-level model of the arbitration and credit rules.
module tb_router_ingress_arbiter;

   localparam int CREDITS = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  req_valid = '0;
   logic [11:0] req_data = '0;
   logic [5:0]  req_dest = '0;
   logic [2:0]  req_ready;
   logic [2:0]  credit_return = '0;
   logic [3:0]  router_data_in;
   logic [1:0]  router_sel;
   logic        router_valid_in;
   logic [2:0]  credit_empty;
   logic [7:0]  drop_count;
   logic        credit_err;

   int errors = 0;
   int checks = 0;

   int m_cred [3];
   int m_ptr, m_drop, m_data, m_sel;
   bit m_vld, m_err;

   router_ingress_arbiter #(.DATA_W(4), .CREDITS(CREDITS), .CNT_W(8)) dut (
      .clk             (clk),
      .rst             (rst),
      .req_valid       (req_valid),
      .req_data        (req_data),
      .req_dest        (req_dest),
      .req_ready       (req_ready),
      .credit_return   (credit_return),
      .router_data_in  (router_data_in),
      .router_sel      (router_sel),
      .router_valid_in (router_valid_in),
      .credit_empty    (credit_empty),
      .drop_count      (drop_count),
      .credit_err      (credit_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int j = 0; j < 3; j++) m_cred[j] = CREDITS;
      m_ptr = 0; m_drop = 0; m_data = 0; m_sel = 0; m_vld = 0; m_err = 0;
   endtask

   function automatic int model_grant();
      for (int k = 0; k < 3; k++) begin
         int i = (m_ptr + k) % 3;
         int d = int'(req_dest[2*i +: 2]);
         if (req_valid[i] && (d == 3 || m_cred[d] > 0)) return i;
      end
      return -1;
   endfunction

   // Settle inputs, then compare every DUT output with the model.
   task automatic sample();
      int g;
      logic [2:0] exp_empty;
      #1;
      g = model_grant();
      for (int j = 0; j < 3; j++) exp_empty[j] = (m_cred[j] == 0);
      chk("req_ready", req_ready, (g < 0) ? 0 : (1 << g));
      chk("credit_empty", credit_empty, exp_empty);
      chk("router_valid_in", router_valid_in, m_vld);
      chk("router_data_in", router_data_in, m_data);
      chk("router_sel", router_sel, m_sel);
      chk("drop_count", drop_count, m_drop);
      chk("credit_err", credit_err, m_err);
   endtask

   // Advance the model by one accepted/idle cycle and step the clock.
   task automatic tick();
      int g, d, n;
      int dec [3];
      for (int j = 0; j < 3; j++) dec[j] = 0;
      g = model_grant();
      m_vld = 0;
      if (g >= 0) begin
         m_ptr = (g + 1) % 3;
         d = int'(req_dest[2*g +: 2]);
         if (d == 3) begin
            if (m_drop < 255) m_drop++;
         end else begin
            m_vld  = 1;
            m_data = int'(req_data[4*g +: 4]);
            m_sel  = d;
            dec[d] = 1;
         end
      end
      for (int j = 0; j < 3; j++) begin
         n = m_cred[j] - dec[j] + int'(credit_return[j]);
         if (n > CREDITS) begin
            n = CREDITS;
            m_err = 1;
         end
         m_cred[j] = n;
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;

      // Reset state
      sample();
      chk("t1_valid", router_valid_in, 0);
      chk("t1_empty", credit_empty, 0);
      chk("t1_drop", drop_count, 0);
      chk("t1_err", credit_err, 0);

      // Fairness: each grant returns the credit of its own output the same cycle
      req_valid = 3'b111;
      req_data  = 12'h321;
      req_dest  = {2'd2, 2'd1, 2'd0};
      for (int c = 0; c < 6; c++) begin
         credit_return = 3'(1 << (c % 3));
         sample();
         chk("t3_grant", req_ready, 1 << (c % 3));
         tick();
         chk("t3_data", router_data_in, (c % 3) + 1);
      end
      credit_return = '0;

      // Single request
      req_valid = 3'b001;
      req_data  = 12'h00A;
      req_dest  = 6'd0;
      sample();
      chk("t2_ready", req_ready, 3'b001);
      tick();
      chk("t2_valid", router_valid_in, 1);
      chk("t2_data", router_data_in, 4'hA);
      chk("t2_sel", router_sel, 0);

      // Credit exhaustion on output 1
      req_dest = 6'd1;
      for (int c = 0; c < 5; c++) begin
         req_data = 12'(c + 4);
         sample();
         if (c < 4) chk("t4_ready", req_ready, 3'b001);
         else begin
            chk("t4_blocked", req_ready, 3'b000);
            chk("t4_empty", credit_empty, 3'b010);
         end
         tick();
      end
      credit_return = 3'b010;
      sample();
      chk("t4_ret_same_cycle", req_ready, 3'b000);
      tick();
      credit_return = '0;
      sample();
      chk("t4_one_more", req_ready, 3'b001);
      tick();
      sample();
      chk("t4_blocked_again", req_ready, 3'b000);
      req_valid = '0;
      tick();

      // Illegal destination
      req_valid = 3'b100;
      req_data  = 12'h100;
      req_dest  = {2'd3, 2'd0, 2'd0};
      sample();
      chk("t5_ready", req_ready, 3'b100);
      tick();
      req_valid = '0;
      chk("t5_valid", router_valid_in, 0);
      chk("t5_drop", drop_count, 1);
      chk("t5_sel_held", router_sel, 1);

      // Overflowing return on output 0 (it sits at CREDITS-1 here)
      credit_return = 3'b001;
      sample(); tick();
      chk("t6_no_err_yet", credit_err, 0);
      sample(); tick();
      chk("t6_err", credit_err, 1);
      credit_return = '0;

      // Accept to output 2 together with a return on output 2
      req_valid     = 3'b001;
      req_data      = 12'h007;
      req_dest      = 6'd2;
      credit_return = 3'b100;
      sample(); tick();
      credit_return = '0;
      req_valid     = '0;

      // Randomised traffic with a reset pulse in the middle
      for (int c = 0; c < 400; c++) begin
         if (c == 200) begin
            rst = 1'b1;
            #1;
            chk("rst_valid", router_valid_in, 0);
            chk("rst_data", router_data_in, 0);
            chk("rst_ready", req_ready, 0);
            chk("rst_empty", credit_empty, 0);
            chk("rst_drop", drop_count, 0);
            chk("rst_err", credit_err, 0);
            model_reset();
            @(posedge clk);
            #1;
            rst = 1'b0;
         end
         req_valid = 3'($urandom_range(0, 7));
         req_data  = 12'($urandom);
         for (int i = 0; i < 3; i++)
            req_dest[2*i +: 2] = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         for (int j = 0; j < 3; j++) begin
            if (m_cred[j] < CREDITS) credit_return[j] = ($urandom_range(0, 9) < 4);
            else                     credit_return[j] = ($urandom_range(0, 99) < 3);
         end
         sample();
         tick();
      end

      req_valid     = '0;
      credit_return = '0;
      sample();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/router_ingress_arbiter.md
Name: router_ingress_arbiter

Overview:
Round-robin arbiter that shares the single ingress port of router_1x3_4bit among three requesters. Each requester presents a 4-bit nibble and a 2-bit destination. The arbiter grants one requester per cycle and drives the router's data_in, sel and valid_in from registers. Per-output credit counters stop any output from being overrun by its downstream consumer. Requests with the illegal destination 2'b11 are accepted, dropped and counted.

Parameters:
DATA_W, 4, nibble width (must match router data_in).
CREDITS, 4, initial and maximum credits per router output; range 1..7.
CNT_W, 8, width of the drop counter.

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
req_valid  in  3  per-requester request valid
req_data  in  3*DATA_W  requester i nibble at [DATA_W*i +: DATA_W]
req_dest  in  6  requester i destination at [2*i +: 2]; 0..2 are legal, 3 is illegal
req_ready  out  3  one-hot accept, combinational; transfer occurs when req_valid[i] & req_ready[i]
credit_return  in  3  one pulse returns one credit for router output j
router_data_in  out  DATA_W  registered, to router data_in
router_sel  out  2  registered, to router sel
router_valid_in  out  1  registered, to router valid_in
credit_empty  out  3  combinational; high when the credit count of output j is 0
drop_count  out  CNT_W  saturating count of illegal-destination requests
credit_err  out  1  sticky; a credit was returned while the counter was already at CREDITS

Behaviour:
- Reset (asynchronous, rst=1):
  - router_data_in=0, router_sel=0, router_valid_in=0.
  - drop_count=0, credit_err=0.
  - Every credit counter = CREDITS; round-robin pointer = 0.
- Eligibility: requester i is eligible when req_valid[i]=1 AND (dest_i==3 OR credit[dest_i]>0).
- Grant:
  - Combinational search starting at the pointer, order ptr, ptr+1, ptr+2 modulo 3.
  - The first eligible requester gets req_ready; at most one bit of req_ready is set.
  - req_ready=0 during reset.
- Accept (a transfer occurs for requester g):
  - The pointer becomes (g+1) mod 3 on the next edge.
  - If no transfer occurs, the pointer holds.
- Output latency: 1 cycle. On the edge after accepting a legal destination:
  - router_data_in=data_g, router_sel=dest_g, router_valid_in=1.
  - credit[dest_g] is decremented.
- Illegal destination (dest_g==3):
  - The request is accepted and the pointer advances.
  - router_valid_in=0 next cycle; router_data_in and router_sel hold their previous values.
  - drop_count increments and saturates at 2^CNT_W-1.
- Idle cycle (no transfer): router_valid_in=0; data and sel hold.
- Credit update per output j, each cycle:
  - Decrement if a legal accept targets j; increment if credit_return[j]=1.
  - Both in the same cycle: count unchanged.
- Credit overflow: credit_return[j] while credit[j]==CREDITS and there is no simultaneous decrement:
  - The count stays at CREDITS.
  - credit_err is set and stays set until reset.
- Credit exhaustion: when credit[j]==0, requesters targeting j are ineligible. Other requesters may still be granted, so there is no head-of-line blocking across requesters.
- Credit return on the exhausting cycle takes effect from the next cycle only; eligibility uses the registered count.
- Reset asserted mid-transfer: outputs clear immediately (asynchronously) and any pending grant is lost. Requesters must re-present their requests after reset.

Decomposition:
- Shared package router_pkg holds:
  - DATA_W.
  - NUM_OUT=3.
  - SEL_W=2.
  - SEL_INVALID=2'b11.
  - Destination encodings OUT0=0, OUT1=1, OUT2=2.
- One sub-module: rr_arbiter3, a pure 3-way round-robin grant with pointer register. Inputs: clk, rst, eligible[2:0], advance. Outputs: grant[2:0], grant_idx[1:0].
- Credit counters, output registers and the drop counter live in the top module.

Test Plan:
1. Reset, then check idle outputs -> all router outputs 0, credit_empty=000, drop_count=0, credit_err=0.
2. Single request: req_valid=001, req_data[3:0]=4'hA, dest0=0 -> req_ready=001 the same cycle; next cycle router_valid_in=1, router_data_in=4'hA, router_sel=0.
3. Fairness: all three valid with dests 0/1/2 and data 1/2/3, held for 6 cycles -> grant order 0,1,2,0,1,2; router_data_in sequence 1,2,3,1,2,3 (credits returned every cycle).
4. Credit exhaustion: CREDITS=4, requester 0 sends 5 nibbles to dest 1 with no returns -> 4 accepted, then credit_empty[1]=1 and req_ready[0]=0. A single credit_return[1] pulse lets exactly one more nibble through.
5. Illegal destination: requester 2 sends data 4'h1 with dest=3 -> req_ready[2]=1, router_valid_in stays 0, drop_count=1, and router_sel retains its prior value.
6. Boundary cases:
   - credit_return[0] at full credits -> credit_err=1, credit count stays at 4.
   - Simultaneous accept to output 2 and credit_return[2] -> count unchanged.
   - rst pulse mid-stream -> outputs 0 immediately and credits restored to 4.
